dec_scan_enable: RTL
====================

// Module: dec_scan_enable
// PURPOSE
//   Registered, parametrised one-hot decoder with enable and an auto-scan mode.
//   Direct mode: registered N-to-2**N decode of 'in', gated by enable.
//   Scan mode: the one-hot output rotates through all 2**n slots, dwelling
//   DWELL clocks per slot. Drives time-multiplexed selects such as display
//   digit strobes and bank selects.
// PARAMETERS
//   n      2   select width; output d is 2**n bits wide
//   DWELL  4   clocks per slot in scan mode; legal range >= 1
// PORTS
//   clk     input   1      system clock, rising edge
//   rst_n   input   1      asynchronous, active-low reset
//   enable  input   1      1 = output active; 0 = d forced to 0, scan frozen
//   mode    input   1      0 = direct decode; 1 = auto-scan
//   in      input   n      slot select, used in direct mode only
//   d       output  2**n   registered one-hot select, or all zeros
//   idx     output  n      registered index of the current slot
//   wrap    output  1      1-clock pulse when scan wraps from 2**n-1 to 0
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous): d=0, idx=0, wrap=0, dwell counter cnt=0.
//   Release: first update at the first rising clk edge with rst_n=1.
//   All outputs are registered; no combinational path from inputs to outputs.
//   Invariant after every edge: d == (enable sampled ? 1<<idx : 0).
//   d never has more than one bit set.
//   Direct mode (mode=0), each edge:
//     - idx <= in (loaded even when enable=0); cnt <= 0; wrap <= 0.
//     - d <= enable ? 1<<in : 0. Latency: 1 clock from in/enable to d.
//   Scan mode (mode=1), enable=1, each edge:
//     - cnt != DWELL-1: cnt <= cnt+1; idx holds.
//     - cnt == DWELL-1: cnt <= 0; idx <= (idx+1) mod 2**n.
//     - wrap <= 1 only on an advance edge where the old idx == 2**n-1; else 0.
//     - d <= 1<<idx_next, where idx_next is the idx value written at this edge.
//     - Each slot is therefore held for exactly DWELL clocks.
//     - DWELL=1: idx advances every clock.
//   Scan mode, enable=0: cnt and idx hold; d <= 0; wrap <= 0.
//     - When enable returns to 1, the scan resumes at the same idx and cnt.
//   Mode change direct->scan: the scan starts at the idx last loaded from in,
//     with cnt=0. That slot gets a full DWELL clocks.
//   Mode change scan->direct: at the next edge, idx <= in, cnt <= 0.
//     No wrap pulse is produced.
//   cnt width: clog2(DWELL), minimum 1 bit. cnt never exceeds DWELL-1.
//   Reset mid-scan: immediate return to reset values. The scan restarts at slot 0.
// TESTING
//   (n=2, DWELL=3 unless stated)
//   1 Reset: rst_n=0 asserted between clock edges -> d=0000, idx=0, wrap=0
//     immediately, with no clock edge needed.
//   2 Direct: mode=0, enable=1, in=2 -> d=0100 at the next edge;
//     enable=0 -> d=0000 at the next edge, idx=2.
//   3 Scan: mode=1, enable=1 from idx=0 -> d sequence 0001 x3, 0010 x3,
//     0100 x3, 1000 x3, then 0001. wrap=1 only on the clock where d returns
//     to 0001.
//   4 Freeze: in scan, enable=0 for 5 clocks mid-slot 1 -> d=0000 and idx=1
//     while low. After release, slot 1 finishes its remaining dwell, then
//     moves to slot 2.
//   5 Mode switch: direct with in=3, then mode=1 -> slot 3 held 3 clocks,
//     then wrap=1 with d=0001.
//   6 DWELL=1, n=3: scan -> idx 0..7 one per clock. wrap pulses every 8 clocks.
//     d is one-hot every clock.

Source files
------------

// File: rtl/dec_scan_enable.sv
// Registered one-hot decoder with enable: direct N-to-2**N decode of 'in', or an
// auto-scan that rotates the active slot, dwelling DWELL clocks on each one.
module dec_scan_enable #(
    parameter int n     = 2,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            mode,
    input  logic [n-1:0]    in,
    output logic [2**n-1:0] d,
    output logic [n-1:0]    idx,
    output logic            wrap
);

    localparam int                 D_W     = 2**n;
    localparam int                 CNT_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DWELL - 1);
    localparam logic [n-1:0]       IDX_MAX = '1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [n-1:0]     idx_nxt;
    logic             wrap_nxt;
    logic [D_W-1:0]   d_nxt;

    // Next-state: direct mode reloads idx from 'in' regardless of enable, scan
    // mode only moves while enabled so a disabled scan resumes where it paused.
    always_comb begin
        idx_nxt  = idx;
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        if (!mode) begin
            idx_nxt = in;
            cnt_nxt = '0;
        end else if (enable) begin
            if (cnt == CNT_MAX) begin
                cnt_nxt  = '0;
                idx_nxt  = idx + 1'b1;
                wrap_nxt = (idx == IDX_MAX);
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
        d_nxt = enable ? (D_W'(1) << idx_nxt) : '0;
    end

    // Output register stage: every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d    <= '0;
            idx  <= '0;
            wrap <= 1'b0;
            cnt  <= '0;
        end else begin
            d    <= d_nxt;
            idx  <= idx_nxt;
            wrap <= wrap_nxt;
            cnt  <= cnt_nxt;
        end
    end

endmodule
